dma_axi_rd_stream: RTL
======================

Name: dma_axi_rd_stream

Overview:
- Parametrised AXI4 read-DMA master, successor to the single-burst read engine.
- Accepts a start address and a total word count, then splits the transfer into INCR bursts of up to MAX_BURST beats.
- Never lets a burst cross a 4 KB boundary.
- Streams read data to a valid/ready sink with backpressure; reports sticky response/protocol errors and a done pulse.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, data width in bits; power of 2, 8..1024.
- LEN_W, 16, width of the total transfer length in words.
- MAX_BURST, 16, maximum beats per burst; power of 2, 1..256.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- start_addr  in  ADDR_W  byte address; must be DATA_W/8 aligned.
- total_len  in  LEN_W  number of words to read.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse when the transfer completes.
- error  out  1  sticky error; cleared by an accepted start.
- out_valid  out  1  stream beat valid.
- out_data  out  DATA_W  stream data.
- out_last  out  1  final word of the whole transfer.
- out_ready  in  1  sink ready.
- m_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arqos  out  widths from dma_axi.vh (araddr ADDR_W, arlen 8).
- m_axi_arvalid  out  1.
- m_axi_arready  in  1.
- m_axi_rdata  in  DATA_W.
- m_axi_rresp  in  2.
- m_axi_rlast  in  1.
- m_axi_rvalid  in  1.
- m_axi_rready  out  1.

Behaviour:
- Reset values: busy=0, done=0, error=0, m_axi_arvalid=0, state IDLE, all counters 0. m_axi_rready and out_valid are 0 because they are gated by state.
- Reset mid-transfer returns to IDLE immediately. No drain of outstanding beats.
- AR constants: arid=0, arsize=log2(DATA_W/8), arburst=01 (INCR), arlock=0, arcache=0x2, arprot=3'b010, qos=0.
- FSM IDLE: on start, latch addr and remaining=total_len and clear error.
  - If total_len==0: done=1 on the next cycle, stay in IDLE, no AXI traffic.
  - Otherwise go to CALC.
  - start while busy is ignored.
- FSM CALC (1 cycle): compute the registered burst length:
  - to4k = (4096 - addr[11:0]) >> arsize
  - beats = min(remaining, MAX_BURST, to4k)
  - arlen = beats-1
  - Go to ADDR.
- FSM ADDR: arvalid=1. araddr and arlen stay stable until arready. On arvalid&&arready, clear the beat counter and go to DATA.
- FSM DATA: pass-through with zero added latency.
  - out_valid = rvalid, out_data = rdata, m_axi_rready = out_ready.
  - A beat is accepted when rvalid && out_ready.
  - On each beat: beat counter +1, remaining -1.
  - out_last = 1 when the beat is accepted with remaining==1.
- End of burst: on the beat where counter == arlen:
  - addr += beats << arsize.
  - If remaining becomes 0: pulse done the next cycle and go to IDLE.
  - Else go to CALC.
- Burst termination is by beat count, not by rlast.
- error is set (sticky) on any accepted beat where any of these holds:
  - rresp != 2'b00;
  - rlast=1 with counter != arlen;
  - rlast=0 with counter == arlen.
- The transfer still runs to completion after an error; error stays high after done until the next accepted start.
- Arithmetic: addr ADDR_W wrap-around is not checked. remaining is LEN_W wide and never underflows because beats ≤ remaining.

Test Plan:
- Aligned single burst: start_addr=0x1000, total_len=8, MAX_BURST=16, arready immediate → one AR with arlen=7; 8 beats out; out_last on beat 8; done one cycle later; error=0.
- Multi-burst split: addr=0x0, total_len=40 → ARs with arlen 15/15/7 at 0x0/0x40/0x80; 40 beats in order; single done.
- 4 KB crossing: addr=0x0FF8, DATA_W=32, total_len=6 → bursts arlen=1 at 0x0FF8, then arlen=3 at 0x1000; no burst crosses 0x1000.
- Backpressure and delays: out_ready toggling 1/0 and arready delayed 3 cycles → m_axi_rready mirrors out_ready; arvalid/araddr held stable; no beats lost or duplicated.
- Errors: rresp=2'b10 on beat 3, early rlast on beat 5 of an 8-beat burst, and rlast missing on the final beat → error=1 sticky after done; a new start clears it.
- Edge commands: total_len=0 → done pulse, no arvalid. Start while busy → ignored. rst asserted during DATA → arvalid/rready/busy all 0 immediately.

Source files
------------

// File: rtl/dma_axi_rd_stream.sv
// AXI4 read-DMA master: splits a word-count transfer into INCR bursts (max MAX_BURST,
// never crossing 4 KB) and streams the read data to a valid/ready sink.
module dma_axi_rd_stream #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  total_len,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic [3:0]        m_axi_arid,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arlock,
    output logic [3:0]        m_axi_arcache,
    output logic [2:0]        m_axi_arprot,
    output logic [3:0]        m_axi_arqos,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    localparam int SIZE = $clog2(DATA_W / 8);
    localparam int CW   = ((LEN_W > 13) ? LEN_W : 13) + 1;

    typedef enum logic [1:0] {IDLE, CALC, ADDR, DATA} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining;
    logic [8:0]        beats_q;
    logic [7:0]        arlen_q;
    logic [7:0]        beat_cnt;

    logic [CW-1:0]     to4k;
    logic [CW-1:0]     lim;
    logic [8:0]        beats_c;
    logic              accept;
    logic              last_of_burst;
    logic              beat_err;

    // Burst size is the smallest of words left, MAX_BURST and beats up to the next 4 KB page.
    always_comb begin
        to4k = CW'((13'd4096 - {1'b0, addr[11:0]}) >> SIZE);
        lim  = CW'(remaining);
        if (lim > CW'(MAX_BURST)) lim = CW'(MAX_BURST);
        if (lim > to4k)           lim = to4k;
        beats_c = 9'(lim);
    end

    assign accept        = (state == DATA) && m_axi_rvalid && out_ready;
    assign last_of_burst = (beat_cnt == arlen_q);
    assign beat_err      = (m_axi_rresp != 2'b00) || (m_axi_rlast != last_of_burst);

    assign m_axi_arid    = 4'd0;
    assign m_axi_araddr  = addr;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = 3'(SIZE);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'h2;
    assign m_axi_arprot  = 3'b010;
    assign m_axi_arqos   = 4'd0;

    // Zero-latency data path: the sink's ready is the AXI ready while a burst is open.
    assign out_valid    = (state == DATA) && m_axi_rvalid;
    assign out_data     = m_axi_rdata;
    assign out_last     = out_valid && (remaining == LEN_W'(1));
    assign m_axi_rready = (state == DATA) && out_ready;

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            addr          <= '0;
            remaining     <= '0;
            beats_q       <= '0;
            arlen_q       <= '0;
            beat_cnt      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            m_axi_arvalid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr      <= start_addr;
                        remaining <= total_len;
                        error     <= 1'b0;
                        if (total_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    beats_q       <= beats_c;
                    arlen_q       <= 8'(beats_c - 9'd1);
                    m_axi_arvalid <= 1'b1;
                    state         <= ADDR;
                end
                ADDR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        beat_cnt      <= '0;
                        state         <= DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        beat_cnt  <= beat_cnt + 8'd1;
                        remaining <= remaining - LEN_W'(1);
                        if (beat_err) error <= 1'b1;
                        // The burst ends on beat count; rlast only feeds the error check.
                        if (last_of_burst) begin
                            addr <= addr + (ADDR_W'(beats_q) << SIZE);
                            if (remaining == LEN_W'(1)) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                state <= CALC;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
